// File: rtl/mod_n_counter_if.sv
// rtl/mod_n_counter_if.sv - control and status bundle for mod_n_counter
interface mod_n_counter_if #(
  parameter int WIDTH = 3
);
  logic             en;
  logic             up;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] din;
  logic             oneshot;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;
  logic             done;
  logic             load_err;

  modport master (
    output en, up, clr, load, din, oneshot,
    input  q, tc, wrap, done, load_err
  );

  modport slave (
    input  en, up, clr, load, din, oneshot,
    output q, tc, wrap, done, load_err
  );
endinterface

// File: rtl/mod_n_counter.sv
// rtl/mod_n_counter.sv - modulo-N up/down counter with load, clear, one-shot and cascade outputs
module mod_n_counter #(
  parameter int WIDTH   = 3,
  parameter int MODULUS = 6
) (
  input logic             clk,
  input logic             reset,
  mod_n_counter_if.slave  bus
);
  // Terminal value as a WIDTH-bit constant so MODULUS = 2^WIDTH never relies on overflow.
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] t;
  logic             wrap_r, done_r, err_r;
  logic             wrap_next, done_next, err_next;
  logic             at_term;

  assign at_term      = bus.up ? (q_r == LAST) : (q_r == ZERO);
  assign bus.tc       = bus.en & at_term;
  assign bus.q        = q_r;
  assign bus.wrap     = wrap_r;
  assign bus.done     = done_r;
  assign bus.load_err = err_r;

  // Next-state selection: clr > load > count; a frozen one-shot ignores en.
  always_comb begin
    q_next    = q_r;
    wrap_next = 1'b0;
    done_next = done_r;
    err_next  = 1'b0;
    if (bus.clr) begin
      q_next    = ZERO;
      done_next = 1'b0;
    end else if (bus.load) begin
      done_next = 1'b0;
      if (bus.din <= LAST) begin
        q_next = bus.din;
      end else begin
        q_next   = LAST;
        err_next = 1'b1;
      end
    end else if (bus.en && !done_r) begin
      if (!at_term) begin
        q_next = bus.up ? q_r + ONE : q_r - ONE;
      end else if (bus.oneshot) begin
        done_next = 1'b1;
      end else begin
        q_next    = bus.up ? ZERO : LAST;
        wrap_next = 1'b1;
      end
    end
  end

  // Per-bit toggle enables, matching the older T-flip-flop counters.
  assign t = q_r ^ q_next;

  // State registers: count bits toggle where t is set, flags load their next values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r    <= ZERO;
      wrap_r <= 1'b0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else begin
      q_r    <= q_r ^ t;
      wrap_r <= wrap_next;
      done_r <= done_next;
      err_r  <= err_next;
    end
  end
endmodule

// File: tb/tb_mod_n_counter.sv
// tb/tb_mod_n_counter.sv - scoreboard bench for mod_n_counter with reference model and cascade
module tb_mod_n_counter;
  localparam int M = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mod_n_counter_if #(.WIDTH(3)) dut_if ();
  mod_n_counter_if #(.WIDTH(4)) lo_if ();
  mod_n_counter_if #(.WIDTH(4)) hi_if ();

  mod_n_counter #(.WIDTH(3), .MODULUS(6)) dut (.clk(clk), .reset(reset), .bus(dut_if));
  mod_n_counter #(.WIDTH(4), .MODULUS(16)) lo (.clk(clk), .reset(reset), .bus(lo_if));
  mod_n_counter #(.WIDTH(4), .MODULUS(10)) hi (.clk(clk), .reset(reset), .bus(hi_if));

  assign hi_if.en = lo_if.tc;

  typedef struct {
    int q;
    bit tc;
    bit wrap;
    bit done;
    bit err;
  } exp_t;

  exp_t sb[$];
  int   casc_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   mq = 0;
  bit   md = 1'b0;

  // Reference model: count value kept as an integer, modular arithmetic per the rules.
  task automatic apply(input bit en, input bit up, input bit clr, input bit load,
                       input int din, input bit os);
    exp_t e;
    int   nq;
    bit   nd, w, er, term;
    @(negedge clk);
    dut_if.en      = en;
    dut_if.up      = up;
    dut_if.clr     = clr;
    dut_if.load    = load;
    dut_if.din     = 3'(din);
    dut_if.oneshot = os;
    nq = mq; nd = md; w = 1'b0; er = 1'b0;
    if (clr) begin
      nq = 0; nd = 1'b0;
    end else if (load) begin
      nd = 1'b0;
      if (din < M) nq = din;
      else begin nq = M - 1; er = 1'b1; end
    end else if (en && !md) begin
      term = up ? (mq == M - 1) : (mq == 0);
      if (term && os) nd = 1'b1;
      else begin
        nq = up ? (mq + 1) % M : (mq + M - 1) % M;
        w  = term;
      end
    end
    mq = nq; md = nd;
    e.q = nq; e.wrap = w; e.done = nd; e.err = er;
    e.tc = en && (up ? (nq == M - 1) : (nq == 0));
    sb.push_back(e);
  endtask

  task automatic async_reset_check(input string name);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    n_vec++;
    if ({dut_if.q, dut_if.wrap, dut_if.done, dut_if.load_err} !== 6'b0) begin
      n_err++;
      $display("FAIL async_reset_%s q=%0d wrap=%0b done=%0b load_err=%0b, expected all 0",
               name, dut_if.q, dut_if.wrap, dut_if.done, dut_if.load_err);
    end
    dut_if.en = 1'b0; dut_if.clr = 1'b0; dut_if.load = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    mq = 0; md = 1'b0;
  endtask

  // Monitor: pops one expectation per edge for each stream that has one pending.
  initial begin
    exp_t e;
    int   exp_c, got_c;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        if ({dut_if.q, dut_if.tc, dut_if.wrap, dut_if.done, dut_if.load_err} !==
            {3'(e.q), e.tc, e.wrap, e.done, e.err}) begin
          n_err++;
          $display("FAIL main q=%0d tc=%0b wrap=%0b done=%0b load_err=%0b, expected q=%0d tc=%0b wrap=%0b done=%0b load_err=%0b",
                   dut_if.q, dut_if.tc, dut_if.wrap, dut_if.done, dut_if.load_err,
                   e.q, e.tc, e.wrap, e.done, e.err);
        end
      end
      if (casc_q.size() > 0) begin
        exp_c = casc_q.pop_front();
        got_c = int'(hi_if.q) * 16 + int'(lo_if.q);
        n_vec++;
        if (got_c != exp_c) begin
          n_err++;
          $display("FAIL cascade count=%0d, expected %0d", got_c, exp_c);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    dut_if.en = 1'b0; dut_if.up = 1'b1; dut_if.clr = 1'b0; dut_if.load = 1'b0;
    dut_if.din = '0; dut_if.oneshot = 1'b0;
    lo_if.en = 1'b0; lo_if.up = 1'b1; lo_if.clr = 1'b0; lo_if.load = 1'b0;
    lo_if.din = '0; lo_if.oneshot = 1'b0;
    hi_if.up = 1'b1; hi_if.clr = 1'b0; hi_if.load = 1'b0;
    hi_if.din = '0; hi_if.oneshot = 1'b0;
    #2;
    n_vec++;
    if ({dut_if.q, dut_if.tc, dut_if.wrap, dut_if.done, dut_if.load_err} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_state q=%0d tc=%0b wrap=%0b done=%0b load_err=%0b, expected all 0",
               dut_if.q, dut_if.tc, dut_if.wrap, dut_if.done, dut_if.load_err);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Up count with wrap: 1,2,3,4,5,0,1,2
    repeat (8) apply(1, 1, 0, 0, 0, 0);
    // Down count from 0: 5,4,3,2,1,0,5
    apply(0, 1, 1, 0, 0, 0);
    repeat (7) apply(1, 0, 0, 0, 0, 0);
    // Direction flip at 3 continues from 3
    apply(0, 1, 1, 0, 0, 0);
    repeat (3) apply(1, 0, 0, 0, 0, 0);
    repeat (2) apply(1, 1, 0, 0, 0, 0);
    // One-shot from 3: 4,5,5,5, then clr and resume
    apply(0, 1, 0, 1, 3, 1);
    repeat (4) apply(1, 1, 0, 0, 0, 1);
    apply(1, 1, 1, 0, 0, 1);
    repeat (2) apply(1, 1, 0, 0, 0, 1);
    // Out-of-range load, clr beats load, load beats count
    apply(0, 1, 0, 1, 7, 0);
    apply(0, 1, 0, 0, 0, 0);
    apply(1, 1, 1, 1, 4, 0);
    apply(1, 1, 0, 1, 2, 0);
    apply(1, 1, 0, 0, 0, 0);
    // Asynchronous reset while done is set
    apply(0, 1, 0, 1, 4, 1);
    repeat (2) apply(1, 1, 0, 0, 0, 1);
    async_reset_check("done");
    // Asynchronous reset during a load_err pulse
    apply(0, 1, 0, 1, 6, 0);
    async_reset_check("load_err");
    // Asynchronous reset during a wrap pulse
    apply(0, 1, 0, 1, 5, 0);
    apply(1, 1, 0, 0, 0, 0);
    async_reset_check("wrap");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      apply($urandom_range(0, 9) != 0, 1'($urandom_range(0, 1)), r < 4, (r >= 4) && (r < 14),
            $urandom_range(0, 7), $urandom_range(0, 9) < 3);
    end

    // Cascade 16 x 10 through tc: full 0..159 and rollover
    for (int k = 0; k < 170; k++) begin
      @(negedge clk);
      lo_if.en = 1'b1;
      casc_q.push_back((k + 1) % 160);
    end
    @(negedge clk);
    lo_if.en = 1'b0;

    repeat (3) @(negedge clk);
    if (sb.size() + casc_q.size() != 0) begin
      $display("FAIL drain pending=%0d, expected 0", sb.size() + casc_q.size());
      n_err += sb.size() + casc_q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
